// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: stores to ADDR_TX queue bytes that are sent as 8N1 frames.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit (8E1, 11-bit frame).
module mmio_uart_tx #(
   parameter logic [31:0] ADDR_TX      = 32'h0001_0044,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   input  logic        bus_we,
   input  logic        bus_re,
   output logic [31:0] bus_rdata,
   output logic        tx,
   output logic        busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [31:0]   ADDR_STAT = ADDR_TX + 32'd4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3
`ifdef MMIO_UART_PARITY_EN
      , S_PARITY = 3'd4
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      data_q, data_d;
   logic            tx_q, tx_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic            wr_sel;
   logic            stat_rd;
   logic            empty;
   logic            full;
   logic            push;
   logic            pop;
   logic            baud_end;
   logic [7:0]      head;
   logic [31:0]     status;
   logic            unused_wdata;

   assign unused_wdata = ^bus_wdata[31:8];

   assign wr_sel   = bus_we && (bus_addr == ADDR_TX);
   assign stat_rd  = bus_re && (bus_addr == ADDR_STAT);
   assign empty    = (count_q == '0);
   assign full     = (count_q == DEPTH_C);
   // A full FIFO never accepts, even when the transmitter pops at the same edge.
   assign push     = wr_sel && !full;
   assign baud_end = (baud_q == BAUD_LAST);
   assign head     = mem_q[rd_ptr_q];

   assign busy      = (state_q != S_IDLE) || !empty;
   assign tx        = tx_q;
   assign bus_rdata = rdata_q;

   assign status = {16'h0000, 8'(count_q), 4'h0, overflow_q, busy, empty, full};

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      data_d  = data_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               data_d  = head;
               tx_d    = 1'b0;
               baud_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               tx_d    = data_q[0];
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                  tx_d    = ^data_q;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = data_q[bit_q + 3'd1];
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
`ifdef MMIO_UART_PARITY_EN
         S_PARITY: begin
            if (baud_end) begin
               baud_d  = '0;
               tx_d    = 1'b1;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
`endif
         S_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               // Chain straight into the next start bit so queued bytes leave with no idle gap.
               if (!empty) begin
                  pop     = 1'b1;
                  data_d  = head;
                  tx_d    = 1'b0;
                  state_d = S_START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            baud_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // A drop in the same cycle as a status read must survive the read-clear.
   always_comb begin
      overflow_d = overflow_q;
      if (wr_sel && full) overflow_d = 1'b1;
      else if (stat_rd)   overflow_d = 1'b0;
      rdata_d = 32'h0;
      if (stat_rd) rdata_d = status;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= 3'd0;
         data_q     <= 8'h00;
         tx_q       <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rdata_q    <= 32'h0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         data_q     <= data_d;
         tx_q       <= tx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         rdata_q    <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus_wdata[7:0];
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random bus traffic, checked cycle by cycle
// against a frame-level reference model and a serial-line decoder with an expected-byte queue.
module tb_mmio_uart_tx;

   localparam logic [31:0] ADDR_TX   = 32'h0001_0044;
   localparam logic [31:0] ADDR_STAT = 32'h0001_0048;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef MMIO_UART_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] bus_addr = 32'h0;
   logic [31:0] bus_wdata = 32'h0;
   logic        bus_we = 1'b0;
   logic        bus_re = 1'b0;
   logic [31:0] bus_rdata;
   logic        tx;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   mmio_uart_tx #(
      .ADDR_TX(ADDR_TX),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus_addr(bus_addr),
      .bus_wdata(bus_wdata),
      .bus_we(bus_we),
      .bus_re(bus_re),
      .bus_rdata(bus_rdata),
      .tx(tx),
      .busy(busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end
   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // FIFO contents as a queue; the transmitter as "cycles left in the current frame".
   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   int         frame_left = 0;
   logic [7:0] cur_byte = 8'h00;
   logic       m_ovf = 1'b0;
   logic [31:0] m_rdata = 32'h0;

   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
`ifdef MMIO_UART_PARITY_EN
      if (i == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   function automatic logic model_tx();
      if (frame_left == 0) return 1'b1;
      return frame_bit(cur_byte, (FRAME - frame_left) / CPB);
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mq.delete();
         exp_q.delete();
         frame_left = 0;
         m_ovf = 1'b0;
         m_rdata = 32'h0;
      end else begin
         int  n;
         bit  wr, srd, mbusy;
         n     = mq.size();
         wr    = bus_we && (bus_addr == ADDR_TX);
         srd   = bus_re && (bus_addr == ADDR_STAT);
         mbusy = (frame_left > 0) || (n > 0);
         m_rdata = srd ? 32'(n * 256 + int'(m_ovf) * 8 + int'(mbusy) * 4 +
                             int'(n == 0) * 2 + int'(n == DEPTH)) : 32'h0;
         if (n > 0 && frame_left <= 1) begin
            cur_byte   = mq.pop_front();
            frame_left = FRAME;
         end else if (frame_left > 0) begin
            frame_left--;
         end
         if (wr && n == DEPTH) m_ovf = 1'b1;
         else if (srd) m_ovf = 1'b0;
         if (wr && n < DEPTH) begin
            mq.push_back(bus_wdata[7:0]);
            exp_q.push_back(bus_wdata[7:0]);
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   bit chk_en = 1'b0;
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("tx_line", 32'(tx), 32'(model_tx()));
         check("busy", 32'(busy), 32'(frame_left > 0 || mq.size() > 0));
         check("rdata", bus_rdata, m_rdata);
      end
   end

   // ---------------- serial decoder / scoreboard ----------------
   bit               mon_act = 1'b0;
   int               mon_t = 0;
   logic [NBITS-1:0] mon_bits = '0;
   logic [NBITS-1:0] mon_last = '0;
   int               frames_seen = 0;
   int               start_q[$];

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         mon_act = 1'b0;
      end else begin
         if (!mon_act && tx == 1'b0) begin
            mon_act = 1'b1;
            mon_t = 0;
            start_q.push_back(cyc);
         end
         if (mon_act) begin
            if (mon_t % CPB == 2) mon_bits[mon_t / CPB] = tx;
            if (mon_t == FRAME - 1) begin
               mon_act = 1'b0;
               frames_seen++;
               mon_last = mon_bits;
               check("rx_start", 32'(mon_bits[0]), 32'h0);
               check("rx_stop", 32'(mon_bits[NBITS-1]), 32'h1);
`ifdef MMIO_UART_PARITY_EN
               check("rx_parity", 32'(mon_bits[9]), 32'(^mon_bits[8:1]));
`endif
               check("rx_sb_nonempty", 32'(exp_q.size() != 0), 32'h1);
               if (exp_q.size() != 0) check("rx_byte", 32'(mon_bits[8:1]), 32'(exp_q.pop_front()));
            end else begin
               mon_t++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic bus_write(input logic [31:0] a, input logic [7:0] d, output int k);
      @(negedge clk);
      bus_we = 1'b1;
      bus_re = 1'b0;
      bus_addr = a;
      bus_wdata = {24'($urandom), d};
      k = cyc + 1;
   endtask

   task automatic bus_idle();
      @(negedge clk);
      bus_we = 1'b0;
      bus_re = 1'b0;
      bus_addr = 32'h0;
      bus_wdata = 32'h0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      bus_we = 1'b0;
      bus_re = 1'b1;
      bus_addr = a;
      @(negedge clk);
      bus_re = 1'b0;
      bus_addr = 32'h0;
      d = bus_rdata;
   endtask

   task automatic wait_idle(input int limit, output int t);
      int i;
      for (i = 0; i < limit; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      t = cyc;
      if (i == limit) check("idle_timeout", 32'(busy), 32'h0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int k, k1, t, fseen;
      logic [31:0] rd;

      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tx", 32'(tx), 32'h1);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_rdata", bus_rdata, 32'h0);
      #2 rst_n = 1'b1;
      bus_read(ADDR_STAT, rd);
      check("reset_status", rd, 32'h0000_0002);

      // single byte: busy falls one full frame after the start edge
      bus_write(ADDR_TX, 8'h41, k);
      bus_idle();
      wait_idle(200, t);
      check("single_busy_fall", 32'(t - k), 32'(FRAME + 1));
      check("single_byte", 32'(mon_last[8:1]), 32'h41);

      // back-to-back frames with no idle gap
      start_q.delete();
      bus_write(ADDR_TX, 8'h55, k1);
      bus_write(ADDR_TX, 8'hAA, k);
      bus_idle();
      wait_idle(300, t);
      check("b2b_busy_fall", 32'(t - k1), 32'(2 * FRAME + 1));
      check("b2b_frames", 32'(start_q.size()), 32'h2);
      if (start_q.size() >= 2) check("b2b_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME));

      // overflow: 0x01 drains at once, 0x02..0x05 fill, 0x06 dropped
      for (int i = 1; i <= 6; i++) bus_write(ADDR_TX, 8'(i), k);
      bus_read(ADDR_STAT, rd);
      check("ovf_status1", rd, 32'h0000_040D);
      bus_read(ADDR_STAT, rd);
      check("ovf_status2", rd, 32'h0000_0405);
      bus_read(ADDR_TX, rd);
      check("txreg_read", rd, 32'h0);
      wait_idle(1000, t);
      check("ovf_last_byte", 32'(mon_last[8:1]), 32'h05);
      check("ovf_sb_drained", 32'(exp_q.size()), 32'h0);

`ifdef MMIO_UART_PARITY_EN
      bus_write(ADDR_TX, 8'h07, k);
      bus_idle();
      wait_idle(200, t);
      check("par_frame_len", 32'(t - k), 32'(45));
      check("par_bit_07", 32'(mon_last[9]), 32'h1);
      bus_write(ADDR_TX, 8'h03, k);
      bus_idle();
      wait_idle(200, t);
      check("par_bit_03", 32'(mon_last[9]), 32'h0);
`endif

      // reset during data bit 3 of 0x0F
      bus_write(ADDR_TX, 8'h0F, k);
      bus_idle();
      repeat (18) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_tx", 32'(tx), 32'h1);
      check("midrst_busy", 32'(busy), 32'h0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      fseen = frames_seen;
      bus_read(ADDR_STAT, rd);
      check("midrst_status", rd, 32'h0000_0002);
      repeat (60) @(negedge clk);
      check("midrst_no_frame", 32'(frames_seen - fseen), 32'h0);

      // random traffic
      for (int it = 0; it < 250; it++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op <= 4) begin
            int n;
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) bus_write(ADDR_TX, 8'($urandom), k);
            bus_idle();
         end else if (op == 5) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
               0:       a = ADDR_STAT;
               1:       a = ADDR_TX - 32'd4;
               2:       a = ADDR_TX ^ 32'h0000_0100;
               default: a = $urandom & 32'hFFFF_FFF0;
            endcase
            bus_write(a, 8'($urandom), k);
            bus_idle();
         end else if (op == 6) begin
            bus_read(ADDR_STAT, rd);
         end else if (op == 7) begin
            bus_read(ADDR_TX, rd);
            check("rand_txreg_read", rd, 32'h0);
         end else if (op == 8) begin
            bus_read($urandom & 32'h00FF_FF00, rd);
         end else begin
            repeat ($urandom_range(1, 40)) @(negedge clk);
         end
      end
      wait_idle(5000, t);
      check("final_sb_drained", 32'(exp_q.size()), 32'h0);
      check("final_tx_idle", 32'(tx), 32'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
